// File: rtl/ps2_direction_decoder_if.sv
// ps2_direction_decoder_if: raw PS/2 lines in, held-direction levels and scan-code strobes out
interface ps2_direction_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic       code_valid;
    logic [7:0] code;
    logic       code_ext;
    logic       code_break;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  up, down, left, right, code_valid, code, code_ext, code_break, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output up, down, left, right, code_valid, code, code_ext, code_break, frame_err
    );
endinterface

// File: rtl/ps2_direction_decoder.sv
// ps2_direction_decoder: PS/2 frame receiver that turns arrow/WASD scan codes into held-direction levels
module ps2_direction_decoder #(
    parameter int CLK_FILTER_LEN = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input logic                    clk,
    input logic                    reset,
    ps2_direction_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    localparam int FW = $clog2(CLK_FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic          ext_pend;
    logic          brk_pend;
    logic [TW-1:0] idle_cnt;
    logic          good;

    // stop bit high and odd parity over data plus parity bit
    assign good = data_sync[1] && ^{shift, par};

    // two-flop synchronizers, idle-high so reset looks like a quiet bus
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk};
            data_sync <= {data_sync[0], bus.ps2_data};
        end
    end

    // filtered clock flips only after CLK_FILTER_LEN consecutive differing samples; fall pulses on 1->0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(CLK_FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    // frame FSM, prefix tracking and direction levels; idle_cnt counts cycles since the last fall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            shift          <= '0;
            par            <= 1'b0;
            idle_cnt       <= '0;
            ext_pend       <= 1'b0;
            brk_pend       <= 1'b0;
            bus.code_valid <= 1'b0;
            bus.code       <= '0;
            bus.code_ext   <= 1'b0;
            bus.code_break <= 1'b0;
            bus.frame_err  <= 1'b0;
            bus.up         <= 1'b0;
            bus.down       <= 1'b0;
            bus.left       <= 1'b0;
            bus.right      <= 1'b0;
        end else begin
            bus.code_valid <= 1'b0;
            bus.frame_err  <= 1'b0;
            if (fall) begin
                idle_cnt <= (state == STOP || (state == IDLE && data_sync[1])) ? '0 : TW'(1);
                case (state)
                    IDLE: begin
                        if (!data_sync[1]) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_sync[1], shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par   <= data_sync[1];
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (!good) begin
                            bus.frame_err <= 1'b1;
                            ext_pend      <= 1'b0;
                            brk_pend      <= 1'b0;
                        end else if (shift == 8'hE0) begin
                            ext_pend <= 1'b1;
                        end else if (shift == 8'hF0) begin
                            brk_pend <= 1'b1;
                        end else begin
                            bus.code_valid <= 1'b1;
                            bus.code       <= shift;
                            bus.code_ext   <= ext_pend;
                            bus.code_break <= brk_pend;
                            ext_pend       <= 1'b0;
                            brk_pend       <= 1'b0;
                            if (ext_pend ? shift == 8'h75 : shift == 8'h1D) bus.up    <= !brk_pend;
                            if (ext_pend ? shift == 8'h72 : shift == 8'h1B) bus.down  <= !brk_pend;
                            if (ext_pend ? shift == 8'h6B : shift == 8'h1C) bus.left  <= !brk_pend;
                            if (ext_pend ? shift == 8'h74 : shift == 8'h23) bus.right <= !brk_pend;
                        end
                    end
                endcase
            end else if (state == IDLE) begin
                idle_cnt <= '0;
            end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state         <= IDLE;
                idle_cnt      <= '0;
                bus.frame_err <= 1'b1;
                ext_pend      <= 1'b0;
                brk_pend      <= 1'b0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
endmodule
